// File: rtl/stage1_pkg.sv
// Shared constants for the stage 1 controller: opcodes, one-hot states, control-word layout.
// Pure declarations; no logic, no latency, no flow control.
// Imported by stage1 and stage1_decode.
package stage1_pkg;

    localparam logic [4:0] OP_NOP = 5'h00;
    localparam logic [4:0] OP_LDA = 5'h01;
    localparam logic [4:0] OP_STA = 5'h02;
    localparam logic [4:0] OP_ADD = 5'h03;
    localparam logic [4:0] OP_SUB = 5'h04;
    localparam logic [4:0] OP_AND = 5'h05;
    localparam logic [4:0] OP_OR  = 5'h0A;
    localparam logic [4:0] OP_XOR = 5'h0B;
    localparam logic [4:0] OP_NOT = 5'h0C;
    localparam logic [4:0] OP_SHL = 5'h0D;
    localparam logic [4:0] OP_LDI = 5'h0F;

    typedef enum logic [6:0] {
        S_IDLE   = 7'b0000001,
        S_ACK    = 7'b0000010,
        S_DECODE = 7'b0000100,
        S_ADDR   = 7'b0001000,
        S_READ   = 7'b0010000,
        S_WRITE  = 7'b0100000,
        S_EXEC   = 7'b1000000
    } state_t;

    localparam int CTRL_IR1_LD  = 0;
    localparam int CTRL_MAR_LD  = 1;
    localparam int CTRL_MEM_RD  = 2;
    localparam int CTRL_MEM_WR  = 3;
    localparam int CTRL_MDR_LD  = 4;
    localparam int CTRL_ACC_LD  = 5;
    localparam int CTRL_CCR_LD  = 6;
    localparam int CTRL_ACC_SRC = 7;
    localparam int CTRL_ALU_OP  = 9;

    typedef enum logic [1:0] {
        SRC_ALU = 2'b00,
        SRC_MDR = 2'b01,
        SRC_IMM = 2'b10
    } acc_src_t;

    typedef enum logic [3:0] {
        ALU_PASS = 4'd0,
        ALU_ADD  = 4'd1,
        ALU_SUB  = 4'd2,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_NOT  = 4'd6,
        ALU_SHL  = 4'd7
    } alu_op_t;

endpackage

// File: rtl/stage1_decode.sv
// Opcode classifier: maps ir[7:3] to an execution class and ALU function.
// Purely combinational, zero latency; no flow control.
module stage1_decode
    import stage1_pkg::*;
(
    input  logic [4:0] opcode,
    output logic       is_memrd,
    output logic       is_store,
    output logic       is_reg,
    output logic       is_imm,
    output logic       is_nop,
    output alu_op_t    alu_op
);

    always_comb begin
        is_memrd = 1'b0;
        is_store = 1'b0;
        is_reg   = 1'b0;
        is_imm   = 1'b0;
        is_nop   = 1'b0;
        alu_op   = ALU_PASS;
        case (opcode)
            OP_LDA: is_memrd = 1'b1;
            OP_STA: is_store = 1'b1;
            OP_ADD: begin is_memrd = 1'b1; alu_op = ALU_ADD; end
            OP_SUB: begin is_memrd = 1'b1; alu_op = ALU_SUB; end
            OP_AND: begin is_memrd = 1'b1; alu_op = ALU_AND; end
            OP_OR:  begin is_memrd = 1'b1; alu_op = ALU_OR;  end
            OP_XOR: begin is_memrd = 1'b1; alu_op = ALU_XOR; end
            OP_NOT: begin is_reg   = 1'b1; alu_op = ALU_NOT; end
            OP_SHL: begin is_reg   = 1'b1; alu_op = ALU_SHL; end
            OP_LDI: is_imm = 1'b1;
            // Stage 0 ops (branches, returns, mask load) fall through as no-ops here.
            default: is_nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/stage1.sv
// Stage 1 Moore controller: accepts one instruction from stage 0, sequences MAR/MEM/MDR/ACC/CCR.
// Latency: accept edge to IDLE is 2 (no-op), 3 (reg/imm), 4 (store), 5 (memory read) cycles.
// Backpressure: requests are only taken in IDLE and only once per stg0_state high period.
module stage1
    import stage1_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic        stg0_state,
    input  logic [7:0]  instr,
    input  logic [7:0]  data,
    output logic        stg1_state,
    output logic [15:0] ctrl,
    output logic [7:0]  dr_out
);

    state_t     state;
    state_t     next_state;
    logic [7:0] ir;
    logic [7:0] dr;
    logic       armed;
    logic       accept;

    logic       is_memrd;
    logic       is_store;
    logic       is_reg;
    logic       is_imm;
    logic       is_nop;
    alu_op_t    alu_op;

    // The modifier field is carried in ir for completeness but has no effect here.
    logic       unused_mod;
    assign unused_mod = ^{ir[2:0], is_nop};

    stage1_decode u_decode (
        .opcode   (ir[7:3]),
        .is_memrd (is_memrd),
        .is_store (is_store),
        .is_reg   (is_reg),
        .is_imm   (is_imm),
        .is_nop   (is_nop),
        .alu_op   (alu_op)
    );

    assign accept = (state == S_IDLE) && stg0_state && armed;
    assign dr_out = dr;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // armed re-arms only after stg0_state is seen low, so a lingering request is taken once.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            ir    <= 8'h00;
            dr    <= 8'h00;
            armed <= 1'b1;
        end else if (accept) begin
            ir    <= instr;
            dr    <= data;
            armed <= 1'b0;
        end else if (!stg0_state) begin
            armed <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (accept) next_state = S_ACK;
            S_ACK:    next_state = S_DECODE;
            S_DECODE: begin
                if (is_memrd || is_store)  next_state = S_ADDR;
                else if (is_reg || is_imm) next_state = S_EXEC;
                else                       next_state = S_IDLE;
            end
            S_ADDR:   next_state = is_store ? S_WRITE : S_READ;
            S_READ:   next_state = S_EXEC;
            S_WRITE:  next_state = S_IDLE;
            S_EXEC:   next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        ctrl       = 16'h0000;
        stg1_state = 1'b0;
        case (state)
            S_ACK: begin
                stg1_state        = 1'b1;
                ctrl[CTRL_IR1_LD] = 1'b1;
            end
            S_ADDR:  ctrl[CTRL_MAR_LD] = 1'b1;
            S_READ: begin
                ctrl[CTRL_MEM_RD] = 1'b1;
                ctrl[CTRL_MDR_LD] = 1'b1;
            end
            S_WRITE: ctrl[CTRL_MEM_WR] = 1'b1;
            S_EXEC: begin
                ctrl[CTRL_ACC_LD] = 1'b1;
                ctrl[CTRL_CCR_LD] = 1'b1;
                if (is_imm) begin
                    ctrl[CTRL_ACC_SRC +: 2] = SRC_IMM;
                end else if (ir[7:3] == OP_LDA) begin
                    ctrl[CTRL_ACC_SRC +: 2] = SRC_MDR;
                end else begin
                    ctrl[CTRL_ACC_SRC +: 2] = SRC_ALU;
                    ctrl[CTRL_ALU_OP  +: 4] = alu_op;
                end
            end
            default: ctrl = 16'h0000;
        endcase
    end

endmodule

// File: tb/tb_stage1.sv
// Scoreboard bench for stage1: expected control-word sequences queued at issue, checked per cycle.
module tb_stage1;

    logic        clk;
    logic        clr;
    logic        stg0_state;
    logic [7:0]  instr;
    logic [7:0]  data;
    logic        stg1_state;
    logic [15:0] ctrl;
    logic [7:0]  dr_out;

    typedef struct {
        logic [7:0]  dr;
        int          len;
        logic [15:0] seq [5];
    } exp_t;

    exp_t exp_q [$];
    exp_t cur;
    int   active;
    int   idx;
    int   ack_cnt;
    int   compared;
    int   mismatched;

    logic [4:0] ops [11] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05,
                             5'h0A, 5'h0B, 5'h0C, 5'h0D, 5'h0F};

    stage1 dut (
        .clk        (clk),
        .clr        (clr),
        .stg0_state (stg0_state),
        .instr      (instr),
        .data       (data),
        .stg1_state (stg1_state),
        .ctrl       (ctrl),
        .dr_out     (dr_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected control words, one per cycle from the ACK cycle until the return to IDLE.
    function automatic exp_t model(input logic [7:0] i, input logic [7:0] d);
        exp_t        e;
        logic [4:0]  op;
        logic [15:0] ex;
        op    = i[7:3];
        e.dr  = d;
        e.len = 2;
        e.seq = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        case (op)
            5'h01:   ex = 16'h00E0;
            5'h03:   ex = 16'h0260;
            5'h04:   ex = 16'h0460;
            5'h05:   ex = 16'h0660;
            5'h0A:   ex = 16'h0860;
            5'h0B:   ex = 16'h0A60;
            5'h0C:   ex = 16'h0C60;
            5'h0D:   ex = 16'h0E60;
            5'h0F:   ex = 16'h0160;
            default: ex = 16'h0000;
        endcase
        if (op == 5'h02) begin
            e.len = 4; e.seq[2] = 16'h0002; e.seq[3] = 16'h0008;
        end else if (op inside {5'h01, 5'h03, 5'h04, 5'h05, 5'h0A, 5'h0B}) begin
            e.len = 5; e.seq[2] = 16'h0002; e.seq[3] = 16'h0014; e.seq[4] = ex;
        end else if (op inside {5'h0C, 5'h0D, 5'h0F}) begin
            e.len = 3; e.seq[2] = ex;
        end
        return e;
    endfunction

    initial begin
        active = 0;
        idx    = 0;
        forever begin
            @(negedge clk);
            if (clr !== 1'b1) begin
                active = 0;
            end else begin
                if (stg1_state === 1'b1) ack_cnt++;
                if (active == 0 && stg1_state === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_ack: got ack with no request queued at %0t", $time);
                    end else begin
                        cur    = exp_q.pop_front();
                        active = 1;
                        idx    = 0;
                        chk("dr_out", 32'(dr_out), 32'(cur.dr));
                    end
                end
                if (active != 0) begin
                    chk("ctrl_seq", 32'(ctrl), 32'(cur.seq[idx]));
                    chk("ack_pulse", 32'(stg1_state), 32'(idx == 0));
                    idx++;
                    if (idx == cur.len) active = 0;
                end else begin
                    chk("idle_out", {15'h0, stg1_state, ctrl}, 32'h0);
                end
            end
        end
    end

    task automatic wait_ack(input bit drop);
        int n;
        n = 0;
        while (stg1_state !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (stg1_state !== 1'b1) begin
            compared++;
            mismatched++;
            $display("FAIL ack_timeout: got no ack within 40 cycles at %0t", $time);
            if (exp_q.size() > 0) exp_q.delete(exp_q.size() - 1);
        end
        instr = 8'($urandom);
        data  = 8'($urandom);
        if (drop) begin
            @(posedge clk); #1;
            stg0_state = 1'b0;
        end
    endtask

    task automatic issue(input logic [7:0] i, input logic [7:0] d);
        exp_q.push_back(model(i, d));
        @(posedge clk); #1;
        instr      = i;
        data       = d;
        stg0_state = 1'b1;
        wait_ack(1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        int         base;
        int         n;
        logic [4:0] op;
        compared   = 0;
        mismatched = 0;
        ack_cnt    = 0;
        clr        = 1'b0;
        stg0_state = 1'b0;
        instr      = 8'h00;
        data       = 8'h00;
        #2;
        chk("reset_ctrl", 32'(ctrl), 32'h0);
        chk("reset_ack", 32'(stg1_state), 32'h0);
        chk("reset_dr", 32'(dr_out), 32'h0);

        // Request already pending when reset releases: armed is set, so it is taken.
        exp_q.push_back(model(8'h78, 8'h05));
        instr      = 8'h78;
        data       = 8'h05;
        stg0_state = 1'b1;
        @(posedge clk); #1;
        clr = 1'b1;
        wait_ack(1'b1);

        issue(8'h08, 8'h3C);
        issue(8'h10, 8'h80);
        issue(8'h20, 8'h11);
        issue(8'h30, 8'h42);

        // Lingering request: one accept only, then a fresh one after a single low cycle.
        base = ack_cnt;
        exp_q.push_back(model(8'h00, 8'h55));
        @(posedge clk); #1;
        instr      = 8'h00;
        data       = 8'h55;
        stg0_state = 1'b1;
        wait_ack(1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("guard_single_ack", 32'(ack_cnt - base), 32'd1);
        stg0_state = 1'b0;
        @(posedge clk); #1;
        exp_q.push_back(model(8'h00, 8'h66));
        instr      = 8'h00;
        data       = 8'h66;
        stg0_state = 1'b1;
        wait_ack(1'b1);
        chk("guard_rearm_ack", 32'(ack_cnt - base), 32'd2);

        // Asynchronous reset in the middle of an LDA read.
        issue(8'h08, 8'hA5);
        n = 0;
        while (ctrl !== 16'h0014 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reach_read", 32'(ctrl), 32'h0014);
        #2;
        clr = 1'b0;
        #1;
        chk("midrst_ctrl", 32'(ctrl), 32'h0);
        chk("midrst_ack", 32'(stg1_state), 32'h0);
        chk("midrst_dr", 32'(dr_out), 32'h0);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        chk("postrst_ctrl", 32'(ctrl), 32'h0);
        chk("postrst_dr", 32'(dr_out), 32'h0);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) op = 5'($urandom);
            else                           op = ops[$urandom_range(0, 10)];
            issue({op, 3'($urandom)}, 8'($urandom));
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end

        repeat (12) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        chk("monitor_idle", 32'(active), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
